uart_receiver: RTL

- Serial receive end of the 8-bit UART. Consumes the oversampling enable from the baud rate generator (tick = 16x baud).
- Recovers start/data/stop framing from the asynchronous `rx` line and presents each byte on a valid/ready output interface.
- Flags framing errors and overruns.
- Sits between the pad-side `rx` pin and the UART host/FIFO logic.

---
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1-style UART receive path: input synchronizer, oversampled framing FSM,
// and a single-entry valid/ready output register with framing/overrun pulses.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   rxs_s;
    logic                   done_s;
    logic                   ferr_s;

    assign rxs_s  = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};

    // Framing FSM: every decision is gated by sample_tick so the FSM freezes between ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_s  = 1'b0;
        ferr_s  = 1'b0;
        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end else begin
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxs_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d  = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxs_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = ST_STOP;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d  = tick_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rxs_s) begin
                            done_s  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_s  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxs_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register: a completed byte loads whenever the slot is empty or being drained.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = ferr_s;
        busy_d      = (state_d != ST_IDLE);
        if (done_s) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State and output registers; the synchronizer presets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync_q      <= {SYNC_STAGES{1'b1}};
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
